// File: rtl/sha_mem_responder.sv
// Word memory shared by a host and a hash engine, with a launch/handshake FSM that audits digest writes.
// Optional watchdog on ARM/RUN is enabled by defining SHA_RESP_WATCHDOG_EN.
module sha_mem_responder #(
  parameter int DEPTH        = 256,
  parameter int DIGEST_WORDS = 8,
  parameter int TIMEOUT      = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  input  logic        host_go,
  input  logic [15:0] msg_addr_cfg,
  input  logic [15:0] out_addr_cfg,
  output logic        start,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic        complete,
  output logic [3:0]  wr_count,
  output logic        err
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [16:0] DW_L    = 17'(DIGEST_WORDS);

  typedef enum logic [1:0] {IDLE, ARM, RUN, FINISH} state_t;
  state_t state_reg;

  logic [31:0] mem [DEPTH];

  logic        host_in_range, eng_in_range, in_window;
  logic        host_wr_en, eng_wr_en, wr_en, wr_inc, err_evt, digest_short;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_count_next;

  always_comb begin
    host_in_range = {1'b0, host_addr} < DEPTH_L;
    eng_in_range  = {1'b0, mem_addr} < DEPTH_L;
    // 17-bit compare so a window near the top of the address space cannot wrap
    in_window     = ({1'b0, mem_addr} >= {1'b0, output_addr}) &&
                    ({1'b0, mem_addr} <  ({1'b0, output_addr} + DW_L));
    host_wr_en    = host_we && !busy && host_in_range;
    eng_wr_en     = mem_we && busy && eng_in_range;
    wr_en         = host_wr_en || eng_wr_en;
    wr_addr       = eng_wr_en ? mem_addr : host_addr;
    wr_data       = eng_wr_en ? mem_write_data : host_wdata;
    wr_inc        = busy && mem_we && in_window && (wr_count != 4'hF);
    wr_count_next = wr_count + {3'b000, wr_inc};
    err_evt       = busy && (!eng_in_range || (mem_we && !in_window));
    digest_short  = 32'(wr_count_next) != DIGEST_WORDS;
  end

  // Single write port (engine has priority), two registered read ports; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_rdata    <= '0;
      mem_read_data <= '0;
    end else begin
      host_rdata    <= host_in_range ? mem[host_addr[AW-1:0]] : '0;
      mem_read_data <= eng_in_range  ? mem[mem_addr[AW-1:0]]  : '0;
    end
  end

`ifdef SHA_RESP_WATCHDOG_EN
  localparam int             WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt_reg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      start        <= 1'b0;
      busy         <= 1'b0;
      complete     <= 1'b0;
      err          <= 1'b0;
      wr_count     <= '0;
      message_addr <= '0;
      output_addr  <= '0;
`ifdef SHA_RESP_WATCHDOG_EN
      wd_cnt_reg   <= '0;
`endif
    end else begin
      complete <= 1'b0;
      wr_count <= wr_count_next;
      err      <= err | err_evt;
      case (state_reg)
        IDLE: if (host_go) begin
          message_addr <= msg_addr_cfg;
          output_addr  <= out_addr_cfg;
          wr_count     <= '0;
          err          <= 1'b0;
          busy         <= 1'b1;
          start        <= 1'b1;
          state_reg    <= ARM;
        end
        ARM: if (!done) begin
          start     <= 1'b0;
          state_reg <= RUN;
        end
        RUN: if (done) state_reg <= FINISH;
        FINISH: begin
          // complete lands together with busy=0 and the final err/wr_count
          complete  <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
          if (digest_short) err <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
`ifdef SHA_RESP_WATCHDOG_EN
      if (state_reg == ARM || state_reg == RUN) begin
        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
        if (wd_cnt_reg == WD_LAST) begin
          err        <= 1'b1;
          start      <= 1'b0;
          complete   <= 1'b1;
          busy       <= 1'b0;
          state_reg  <= IDLE;
          wd_cnt_reg <= '0;
        end
      end else begin
        wd_cnt_reg <= '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_sha_mem_responder.sv
// Randomized scoreboard bench for sha_mem_responder; reference model tracks memory and run outcome.
module tb_sha_mem_responder;
  localparam int DEPTH = 256;
  localparam int DW    = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic [31:0] host_rdata;
  logic        host_go = 1'b0;
  logic [15:0] msg_addr_cfg = '0, out_addr_cfg = '0;
  logic        start;
  logic [15:0] message_addr, output_addr;
  logic        done = 1'b1;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        busy, complete, err;
  logic [3:0]  wr_count;

  sha_mem_responder #(.DEPTH(DEPTH), .DIGEST_WORDS(DW)) dut (
    .clk(clk), .reset_n(reset_n), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_go(host_go),
    .msg_addr_cfg(msg_addr_cfg), .out_addr_cfg(out_addr_cfg), .start(start),
    .message_addr(message_addr), .output_addr(output_addr), .done(done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy), .complete(complete),
    .wr_count(wr_count), .err(err));

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] wc; logic e; } cpl_t;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] host_q [$];
  logic [31:0] eng_q [$];
  cpl_t        cpl_q [$];
  cpl_t        mc;
  logic        h_issue = 1'b0, e_issue = 1'b0, h_pend = 1'b0, e_pend = 1'b0;
  int          n_cmp = 0, n_bad = 0, n_cpl = 0, exp_cpl = 0;
  int          run_wc, run_out;
  bit          run_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_pend <= 1'b0;
      e_pend <= 1'b0;
    end else begin
      h_pend <= h_issue;
      e_pend <= e_issue;
    end
  end

  // Monitor: pops expectations whenever a read result or a complete pulse is presented.
  always @(negedge clk) begin
    if (h_pend) begin
      if (host_q.size() == 0) check("host_q_size", 32'(host_q.size()), 32'd1);
      else check("host_rdata", host_rdata, host_q.pop_front());
    end
    if (e_pend) begin
      if (eng_q.size() == 0) check("eng_q_size", 32'(eng_q.size()), 32'd1);
      else check("mem_read_data", mem_read_data, eng_q.pop_front());
    end
    if (complete) begin
      n_cpl++;
      if (cpl_q.size() == 0) check("cpl_q_size", 32'(cpl_q.size()), 32'd1);
      else begin
        mc = cpl_q.pop_front();
        check("wr_count", 32'(wr_count), 32'(mc.wc));
        check("err", 32'(err), 32'(mc.e));
        check("busy_at_complete", 32'(busy), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input logic [31:0] d);
    host_we = 1'b1; host_addr = 16'(a); host_wdata = d;
    tick();
    host_we = 1'b0;
    if (a < DEPTH) model_mem[a] = d;
  endtask

  task automatic host_read(input int a);
    host_addr = 16'(a); h_issue = 1'b1;
    host_q.push_back((a < DEPTH) ? model_mem[a] : 32'h0);
    tick();
    h_issue = 1'b0;
  endtask

  task automatic eng_read(input int a);
    mem_addr = 16'(a); e_issue = 1'b1;
    eng_q.push_back((a < DEPTH) ? model_mem[a] : 32'h0);
    if (a >= DEPTH) run_err = 1'b1;
    tick();
    e_issue = 1'b0; mem_addr = '0;
  endtask

  task automatic eng_write(input int a, input logic [31:0] d);
    mem_we = 1'b1; mem_addr = 16'(a); mem_write_data = d;
    tick();
    mem_we = 1'b0; mem_addr = '0;
    if (a < DEPTH) model_mem[a] = d;
    else run_err = 1'b1;
    if (a >= run_out && a < run_out + DW) run_wc = (run_wc < 15) ? run_wc + 1 : 15;
    else run_err = 1'b1;
  endtask

  task automatic run(input int msg, input int outb, input int nwr, input int stray,
                     input bit oor_rd, input bit poke);
    int t;
    cpl_t c;
    msg_addr_cfg = 16'(msg); out_addr_cfg = 16'(outb); host_go = 1'b1;
    tick();
    host_go = 1'b0;
    run_wc = 0; run_err = 1'b0; run_out = outb;
    check("busy_after_go", 32'(busy), 32'd1);
    check("message_addr", 32'(message_addr), 32'(msg));
    check("output_addr", 32'(output_addr), 32'(outb));
    t = 0;
    while (start !== 1'b1 && t < 20) begin tick(); t++; end
    check("start_seen", 32'(start), 32'd1);
    done = 1'b0;
    tick();
    check("start_dropped", 32'(start), 32'd0);
    for (int i = 0; i < 20; i++) eng_read(msg + i);
    if (oor_rd) eng_read(300);
    if (poke) begin
      host_we = 1'b1; host_addr = 16'd3; host_wdata = $urandom;
      tick();
      host_we = 1'b0;
    end
    for (int i = 0; i < nwr; i++) eng_write(outb + (i % DW), $urandom);
    if (stray >= 0) eng_write(stray, $urandom);
    c.wc = 4'(run_wc);
    c.e  = run_err || (run_wc != DW);
    cpl_q.push_back(c);
    exp_cpl++;
    done = 1'b1;
    tick();
    t = 0;
    while (busy !== 1'b0 && t < 10) begin tick(); t++; end
    check("busy_cleared", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_complete"}, 32'(complete), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_wr_count"}, 32'(wr_count), 32'd0);
    check({tag, "_message_addr"}, 32'(message_addr), 32'd0);
    check({tag, "_output_addr"}, 32'(output_addr), 32'd0);
    check({tag, "_host_rdata"}, host_rdata, 32'd0);
    check({tag, "_mem_read_data"}, mem_read_data, 32'd0);
  endtask

`ifdef SHA_RESP_WATCHDOG_EN
  logic        wd_go = 1'b0;
  logic [31:0] wd_hr, wd_mr;
  logic [15:0] wd_ma, wd_oa;
  logic        wd_start, wd_busy, wd_cpl, wd_err;
  logic [3:0]  wd_wc;
  sha_mem_responder #(.DEPTH(DEPTH), .DIGEST_WORDS(DW), .TIMEOUT(16)) wd_dut (
    .clk(clk), .reset_n(reset_n), .host_we(1'b0), .host_addr(16'h0), .host_wdata(32'h0),
    .host_rdata(wd_hr), .host_go(wd_go), .msg_addr_cfg(16'h0), .out_addr_cfg(16'h20),
    .start(wd_start), .message_addr(wd_ma), .output_addr(wd_oa), .done(1'b0),
    .mem_we(1'b0), .mem_addr(16'h0), .mem_write_data(32'h0), .mem_read_data(wd_mr),
    .busy(wd_busy), .complete(wd_cpl), .wr_count(wd_wc), .err(wd_err));
`endif

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int msg, outb, nwr, stray, a;
    #2;
    check_reset_state("por");
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) host_write(i, $urandom);
    for (int i = 0; i < 20; i++) host_write(i, 32'(i + 1));
    host_read(5);
    tick();

    run(0, 32, 8, -1, 1'b0, 1'b0);
    for (int i = 32; i < 40; i++) host_read(i);
    run(0, 32, 7, 50, 1'b0, 1'b0);
    run(0, 32, 8, -1, 1'b1, 1'b1);
    host_read(3);
    host_read(300);

    // Abort a run with reset: no complete pulse, memory keeps its contents
    msg_addr_cfg = 16'd4; out_addr_cfg = 16'd100; host_go = 1'b1;
    tick();
    host_go = 1'b0; done = 1'b0; run_out = 100; run_wc = 0; run_err = 1'b0;
    tick();
    eng_write(100, $urandom);
    eng_write(101, $urandom);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_state("midrun");
    done = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("no_complete_after_reset", 32'(n_cpl), 32'(exp_cpl));
    run(0, 32, 8, -1, 1'b0, 1'b0);
    host_read(100);
    host_read(101);

    // Window at the top of memory, then a write just past the end of memory
    run(10, DEPTH - DW, 8, -1, 1'b0, 1'b0);
    run(10, DEPTH - DW, 8, DEPTH, 1'b0, 1'b0);
    run(20, 0, 18, -1, 1'b0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 6; k++) begin
        a = $urandom_range(0, DEPTH + 40);
        if ($urandom_range(0, 1) == 0) host_write(a, $urandom);
        else host_read(a);
      end
      msg  = $urandom_range(0, DEPTH - 20);
      outb = $urandom_range(0, DEPTH - DW);
      nwr  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 18) : DW;
      stray = -1;
      if ($urandom_range(0, 3) == 0) stray = (outb + DW < DEPTH) ? outb + DW : outb - 1;
      run(msg, outb, nwr, stray, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      host_read(outb + $urandom_range(0, DW - 1));
      host_read(3);
    end

`ifdef SHA_RESP_WATCHDOG_EN
    wd_go = 1'b1;
    tick();
    wd_go = 1'b0;
    repeat (15) tick();
    check("wd_complete_early", 32'(wd_cpl), 32'd0);
    tick();
    check("wd_complete", 32'(wd_cpl), 32'd1);
    check("wd_err", 32'(wd_err), 32'd1);
    check("wd_busy", 32'(wd_busy), 32'd0);
`endif

    repeat (3) tick();
    check("complete_count", 32'(n_cpl), 32'(exp_cpl));
    check("host_q_left", 32'(host_q.size()), 32'd0);
    check("eng_q_left", 32'(eng_q.size()), 32'd0);
    check("cpl_q_left", 32'(cpl_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sha_mem_responder.md
SHA_MEM_RESPONDER -- requirements
Module: sha_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words in the memory array.
REQ-002 SHALL have parameter DIGEST_WORDS, default 8, meaning the number of digest words expected from the hash engine.
REQ-003 SHALL have parameter TIMEOUT, default 4096, meaning the watchdog limit in cycles.
REQ-004 Ports, in order, SHALL be:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- host_we  in  1  host write strobe.
- host_addr  in  16  host word address.
- host_wdata  in  32  host write data.
- host_rdata  out  32  host read data.
- host_go  in  1  launch pulse.
- msg_addr_cfg  in  16  message base address.
- out_addr_cfg  in  16  digest base address.
- start  out  1  engine start.
- message_addr  out  16  engine message base.
- output_addr  out  16  engine digest base.
- done  in  1  engine idle/done.
- mem_we  in  1  engine write strobe.
- mem_addr  in  16  engine word address.
- mem_write_data  in  32  engine write data.
- mem_read_data  out  32  engine read data.
- busy  out  1  run in progress.
- complete  out  1  one-cycle end-of-run pulse.
- wr_count  out  4  digest writes captured.
- err  out  1  sticky protocol error.

Function
REQ-005 SHALL implement DEPTH x 32 memory; the host port and the engine port SHALL each have 1-cycle registered read latency: rdata at edge N+1 = mem[addr at edge N].
REQ-006 Addresses >= DEPTH SHALL read 32'h0 and drop writes; an engine access with such an address while busy SHALL set err.
REQ-007 Host writes SHALL take effect only when busy=0; host_we while busy=1 SHALL be ignored. Host reads SHALL work at all times.
REQ-008 Engine writes SHALL take effect only when busy=1; engine reads SHALL always be serviced.
REQ-009 FSM states SHALL be IDLE, ARM, RUN, FINISH.
REQ-010 IDLE: on host_go=1, the block SHALL latch msg_addr_cfg and out_addr_cfg onto message_addr and output_addr, clear wr_count and err, set busy=1, and go to ARM; host_go outside IDLE SHALL be ignored.
REQ-011 ARM: start SHALL be 1; on the first cycle done=0, the block SHALL drop start and go to RUN.
REQ-012 RUN: start SHALL be 0; on done=1, the block SHALL go to FINISH.
REQ-013 FINISH: the block SHALL assert complete for exactly one cycle, clear busy, and return to IDLE.
REQ-014 Each engine write while busy with output_addr <= mem_addr < output_addr+DIGEST_WORDS SHALL increment wr_count, saturating at 15.
REQ-015 An engine write while busy outside that window SHALL set err; the write still lands if the address is in range.
REQ-016 In FINISH, err SHALL be set if wr_count != DIGEST_WORDS.
REQ-017 Window comparison SHALL use 17-bit arithmetic so that output_addr+DIGEST_WORDS does not wrap.
REQ-018 If a host write and an engine write target the same word in one cycle, the engine write SHALL win (the host write is only possible when busy=0, where it is ignored per REQ-007/008).

Reset
REQ-019 Asserting reset_n low SHALL asynchronously force: state=IDLE; start, busy, complete, err = 0; wr_count=0; message_addr, output_addr, host_rdata, mem_read_data = 0.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 Reset mid-run SHALL abandon the run with no complete pulse.

Configuration
REQ-022 With macro SHA_RESP_WATCHDOG_EN defined, a cycle counter SHALL run in ARM and RUN. On reaching TIMEOUT, the block SHALL set err, drop start, pulse complete, clear busy, and return to IDLE.
REQ-023 Without SHA_RESP_WATCHDOG_EN, no counter SHALL exist and ARM/RUN SHALL wait indefinitely.

Verification
REQ-024 Host writes mem[0..19]=i+1, reads back addr 5 -> host_rdata=32'h6 one cycle later.
REQ-025 host_go with msg=0, out=32; stub engine reads 20 words then writes 8 to 32..39 -> complete once, wr_count=8, err=0, mem[32..39] = the written values.
REQ-026 Stub writes 7 digest words and one to address 50 -> err=1 at complete, wr_count=7.
REQ-027 host_we to addr 3 during busy -> mem[3] unchanged after run; engine read of addr 300 -> mem_read_data=0, err=1.
REQ-028 reset_n low during RUN -> busy=0, start=0, no complete; a new host_go then runs normally.
REQ-029 With SHA_RESP_WATCHDOG_EN, TIMEOUT=16, done held 0 -> complete and err=1 sixteen cycles after entering ARM.
